// File: rtl/fp32_seq_multiplier_if.sv
// Operand/result handshake bundle for fp32_seq_multiplier.
interface fp32_seq_multiplier_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;

    modport master (output in_valid, a, b, out_ready,
                    input  in_ready, out_valid, result, overflow, underflow);
    modport slave  (input  in_valid, a, b, out_ready,
                    output in_ready, out_valid, result, overflow, underflow);
endinterface

// File: rtl/fp32_seq_multiplier.sv
// Multi-cycle fp32 multiplier: 24-step shift-add significand product, one NORM cycle.
// Optional macro FP32_ROUND_NEAREST_EN selects round-to-nearest-even; default truncates.
module fp32_seq_multiplier #(
    parameter int          MUL_STEPS   = 24,
    parameter logic [31:0] NAN_PATTERN = 32'h7FC00000
) (
    input logic                  clk,
    input logic                  reset,
    fp32_seq_multiplier_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t      r_state;
    logic [23:0] r_ma, r_mb;
    logic [47:0] r_acc;
    logic [4:0]  r_cnt;
    logic        r_sign;
    logic [7:0]  r_ea, r_eb;
    logic [31:0] r_result;
    logic        r_ovf, r_unf, r_out_valid, r_in_ready;

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.overflow  = r_ovf;
    assign bus.underflow = r_unf;

    logic w_sign, w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero, w_invalid;
    assign w_sign    = bus.a[31] ^ bus.b[31];
    assign w_a_nan   = (&bus.a[30:23]) && (|bus.a[22:0]);
    assign w_b_nan   = (&bus.b[30:23]) && (|bus.b[22:0]);
    assign w_a_inf   = (&bus.a[30:23]) && !(|bus.a[22:0]);
    assign w_b_inf   = (&bus.b[30:23]) && !(|bus.b[22:0]);
    assign w_a_zero  = (bus.a[30:23] == 8'd0);
    assign w_b_zero  = (bus.b[30:23] == 8'd0);
    assign w_invalid = w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero);

    logic signed [9:0] w_e_base, w_e, w_e_fin;
    logic [22:0]       w_frac, w_frac_fin;
`ifdef FP32_ROUND_NEAREST_EN
    logic              w_guard, w_sticky;
    logic [23:0]       w_frac_rnd;
`endif

    always_comb begin
        w_e_base = $signed({2'b00, r_ea} + {2'b00, r_eb} - 10'd127);
        if (r_acc[47]) begin
            w_frac = r_acc[46:24];
            w_e    = w_e_base + 10'sd1;
        end else begin
            w_frac = r_acc[45:23];
            w_e    = w_e_base;
        end
`ifdef FP32_ROUND_NEAREST_EN
        w_guard    = r_acc[47] ? r_acc[23] : r_acc[22];
        w_sticky   = r_acc[47] ? (|r_acc[22:0]) : (|r_acc[21:0]);
        w_frac_rnd = {1'b0, w_frac} + {23'd0, (w_guard && (w_sticky || w_frac[0]))};
        // carry out of the fraction renormalises to 1.0 x 2^(e+1)
        w_frac_fin = w_frac_rnd[22:0];
        w_e_fin    = w_frac_rnd[23] ? (w_e + 10'sd1) : w_e;
`else
        w_frac_fin = w_frac;
        w_e_fin    = w_e;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_ma        <= '0;
            r_mb        <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sign      <= 1'b0;
            r_ea        <= '0;
            r_eb        <= '0;
            r_result    <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid && r_in_ready) begin
                    r_in_ready <= 1'b0;
                    r_sign     <= w_sign;
                    r_ea       <= bus.a[30:23];
                    r_eb       <= bus.b[30:23];
                    r_ma       <= {1'b1, bus.a[22:0]};
                    r_mb       <= {1'b1, bus.b[22:0]};
                    if (w_invalid) begin
                        r_result <= NAN_PATTERN;
                        r_state  <= DONE;
                    end else if (w_a_inf || w_b_inf) begin
                        r_result <= {w_sign, 8'hFF, 23'h0};
                        r_state  <= DONE;
                    end else if (w_a_zero || w_b_zero) begin
                        r_result <= {w_sign, 31'h0};
                        r_state  <= DONE;
                    end else begin
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= MUL;
                    end
                end
                MUL: begin
                    if (r_mb[r_cnt])
                        r_acc <= r_acc + ({24'd0, r_ma} << r_cnt);
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'(MUL_STEPS - 1))
                        r_state <= NORM;
                end
                NORM: begin
                    if (w_e_fin >= 10'sd255) begin
                        r_result <= {r_sign, 8'hFF, 23'h0};
                        r_ovf    <= 1'b1;
                    end else if (w_e_fin <= 10'sd0) begin
                        r_result <= {r_sign, 31'h0};
                        r_unf    <= 1'b1;
                    end else begin
                        r_result <= {r_sign, w_e_fin[7:0], w_frac_fin};
                    end
                    r_state <= DONE;
                end
                DONE: begin
                    // first DONE edge raises out_valid; handoff happens on a later edge
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_ovf       <= 1'b0;
                        r_unf       <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp32_seq_multiplier.sv
// Directed self-checking bench for fp32_seq_multiplier.
module tb_fp32_seq_multiplier;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    fp32_seq_multiplier_if bus();

    fp32_seq_multiplier dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Drive one operation; return once out_valid is seen (or budget expires, lat=100).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit hold_valid,
                          output logic [31:0] res, output logic ovf, output logic unf,
                          output int lat, output bit busy_ok);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.a         = a;
        bus.b         = b;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = hold_valid;
        bus.a = $urandom;
        bus.b = $urandom;
        lat = 0;
        busy_ok = 1'b1;
        while (lat < 100) begin
            if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
            if (bus.out_valid === 1'b1) break;
        end
        bus.in_valid = 1'b0;
        res = bus.result;
        ovf = bus.overflow;
        unf = bus.underflow;
    endtask

    task automatic handoff();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks += 5;
        if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        if (bus.result !== 32'h0)   begin errors++; $display("FAIL reset_result got=%h exp=0", bus.result); end
        if (bus.overflow !== 1'b0)  begin errors++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
        if (bus.underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got=%b exp=0", bus.underflow); end
    endtask

    task automatic test_normal();
        logic [31:0] r; logic o, u; int lat; bit busy;
        run_op(32'h40000000, 32'h40400000, 1'b1, r, o, u, lat, busy);
        checks += 5;
        if (r !== 32'h40C00000) begin errors++; $display("FAIL mul_2x3 got=%h exp=40c00000", r); end
        if ({o, u} !== 2'b00)   begin errors++; $display("FAIL mul_2x3_flags got=%b exp=00", {o, u}); end
        if (lat != 26)          begin errors++; $display("FAIL mul_2x3_latency got=%0d exp=26", lat); end
        if (!busy)              begin errors++; $display("FAIL mul_2x3_in_ready_busy got=1 exp=0"); end
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mul_2x3_in_ready_done got=%b exp=0", bus.in_ready); end
        handoff();
        checks += 2;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL handoff_out_valid got=%b exp=0", bus.out_valid); end
        if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL handoff_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_sign();
        logic [31:0] r; logic o, u; int lat; bit busy;
        run_op(32'hBFC00000, 32'h40800000, 1'b0, r, o, u, lat, busy);
        checks += 2;
        if (r !== 32'hC0C00000) begin errors++; $display("FAIL mul_neg got=%h exp=c0c00000", r); end
        if (lat != 26)          begin errors++; $display("FAIL mul_neg_latency got=%0d exp=26", lat); end
        handoff();
    endtask

    task automatic test_special();
        logic [31:0] va [3] = '{32'h00000000, 32'h7F800000, 32'h7F800000};
        logic [31:0] vb [3] = '{32'hC2F60000, 32'h7F800000, 32'h00000000};
        logic [31:0] ve [3] = '{32'h80000000, 32'h7F800000, 32'h7FC00000};
        logic [31:0] r; logic o, u; int lat; bit busy;
        for (int k = 0; k < 3; k++) begin
            run_op(va[k], vb[k], 1'b0, r, o, u, lat, busy);
            checks += 3;
            if (r !== ve[k])      begin errors++; $display("FAIL special%0d got=%h exp=%h", k, r, ve[k]); end
            if (lat != 1)         begin errors++; $display("FAIL special%0d_latency got=%0d exp=1", k, lat); end
            if ({o, u} !== 2'b00) begin errors++; $display("FAIL special%0d_flags got=%b exp=00", k, {o, u}); end
            handoff();
        end
    endtask

    task automatic test_overflow();
        logic [31:0] r; logic o, u; int lat; bit busy;
        run_op(32'h7F000000, 32'h7F000000, 1'b0, r, o, u, lat, busy);
        checks += 2;
        if (r !== 32'h7F800000) begin errors++; $display("FAIL ovf_result got=%h exp=7f800000", r); end
        if ({o, u} !== 2'b10)   begin errors++; $display("FAIL ovf_flags got=%b exp=10", {o, u}); end
        handoff();
        checks++;
        if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", bus.overflow); end
    endtask

    task automatic test_underflow();
        logic [31:0] r; logic o, u; int lat; bit busy;
        run_op(32'h00800000, 32'h00800000, 1'b0, r, o, u, lat, busy);
        checks += 3;
        if (r !== 32'h00000000) begin errors++; $display("FAIL unf_result got=%h exp=0", r); end
        if ({o, u} !== 2'b01)   begin errors++; $display("FAIL unf_flags got=%b exp=01", {o, u}); end
        if (lat != 26)          begin errors++; $display("FAIL unf_latency got=%0d exp=26", lat); end
        handoff();
        checks++;
        if (bus.underflow !== 1'b0) begin errors++; $display("FAIL unf_clear got=%b exp=0", bus.underflow); end
    endtask

    task automatic test_backpressure();
        logic [31:0] r; logic o, u; int lat; bit busy;
        run_op(32'hBFC00000, 32'h40800000, 1'b0, r, o, u, lat, busy);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks += 3;
            if (bus.out_valid !== 1'b1)   begin errors++; $display("FAIL bp_out_valid c%0d got=%b exp=1", c, bus.out_valid); end
            if (bus.result !== 32'hC0C00000) begin errors++; $display("FAIL bp_result c%0d got=%h exp=c0c00000", c, bus.result); end
            if (bus.in_ready !== 1'b0)    begin errors++; $display("FAIL bp_in_ready c%0d got=%b exp=0", c, bus.in_ready); end
        end
        handoff();
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r; logic o, u; int lat; bit busy;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a = 32'h3FC00000;
        bus.b = 32'h40400000;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checks += 3;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid got=%b exp=0", bus.out_valid); end
        if (bus.result !== 32'h0)   begin errors++; $display("FAIL rst_mid_result got=%h exp=0", bus.result); end
        if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL rst_mid_in_ready got=%b exp=1", bus.in_ready); end
        @(negedge clk); reset = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        checks += 2;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_abort_no_output got=%b exp=0", bus.out_valid); end
        if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL rst_release_in_ready got=%b exp=1", bus.in_ready); end
        run_op(32'h40000000, 32'h40400000, 1'b0, r, o, u, lat, busy);
        checks += 2;
        if (r !== 32'h40C00000) begin errors++; $display("FAIL rst_next_op got=%h exp=40c00000", r); end
        if (lat != 26)          begin errors++; $display("FAIL rst_next_latency got=%0d exp=26", lat); end
        handoff();
    endtask

    task automatic test_rounding();
        logic [31:0] r; logic o, u; int lat; bit busy;
        logic [31:0] exp_r;
`ifdef FP32_ROUND_NEAREST_EN
        exp_r = 32'h40100001;
`else
        exp_r = 32'h40100000;
`endif
        run_op(32'h3FC00001, 32'h3FC00000, 1'b0, r, o, u, lat, busy);
        checks += 2;
        if (r !== exp_r) begin errors++; $display("FAIL rounding got=%h exp=%h", r, exp_r); end
        if (lat != 26)   begin errors++; $display("FAIL rounding_latency got=%0d exp=26", lat); end
        handoff();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        #12;
        test_reset();
        @(negedge clk); reset = 1'b1;
        test_normal();
        test_sign();
        test_special();
        test_overflow();
        test_underflow();
        test_backpressure();
        test_reset_mid();
        test_rounding();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
